// File: rtl/winlose_ctrl_pkg.sv
// Shared definitions for the win/lose result screen: scene codes, FSM state
// encoding and counter widths.
package winlose_ctrl_pkg;

  // Scene codes shared with the scene FSM and the renderers.
  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_MENU  = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_SCORE = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;
  localparam logic [2:0] S_LOSE  = 3'd6;

  localparam int LOCK_W = 8;

  typedef enum logic [1:0] {
    WL_IDLE  = 2'd0,
    WL_SHOW  = 2'd1,
    WL_ARMED = 2'd2,
    WL_EXIT  = 2'd3
  } wl_state_t;

endpackage

// File: rtl/winlose_ctrl_if.sv
// Signal bundle between the play/scene logic and the result-screen controller.
interface winlose_ctrl_if;
  import winlose_ctrl_pkg::*;

  // game_over and to_menu are single-cycle pulses with no back-pressure; tap is
  // a level. Every output is valid every cycle and comes from registered state.
  logic       game_over;
  logic       game_won;
  logic       tap;
  logic       active;
  logic [2:0] scene_wl;
  logic [3:0] winLose_cnt;
  logic       armed;
  logic       to_menu;
  wl_state_t  state;

  modport master (
    output game_over, game_won, tap,
    input  active, scene_wl, winLose_cnt, armed, to_menu, state
  );

  modport slave (
    input  game_over, game_won, tap,
    output active, scene_wl, winLose_cnt, armed, to_menu, state
  );

endinterface

// File: rtl/winlose_ctrl_tick_gen.sv
// Free-running prescaler that emits one tick every DIV enabled cycles.
module tick_gen #(
  parameter int DIV = 6_250_000
) (
  input  logic rst,
  input  logic clk,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/winlose_ctrl.sv
// Result-screen controller: latches win/lose, blinks a counter, locks out taps
// for a while, then returns to the menu on a fresh tap press.
module winlose_ctrl
  import winlose_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 6_250_000,
  parameter int LOCK_TICKS = 16
) (
  input  logic           clk,
  input  logic           rst,
  winlose_ctrl_if.slave  bus
);

  wl_state_t         state;
  wl_state_t         next_state;
  logic              tap_q;
  logic              tap_edge;
  logic              tick;
  logic              presc_en;
  logic              presc_clr;
  logic              lock_done;
  logic [LOCK_W-1:0] lock_cnt;
  logic [3:0]        cnt;
  logic [2:0]        scene_q;
  logic              active_d;
  logic              armed_d;
  logic              to_menu_d;

  assign tap_edge  = bus.tap && !tap_q;
  assign lock_done = (lock_cnt == LOCK_W'(LOCK_TICKS));
  assign presc_en  = (state == WL_SHOW) || (state == WL_ARMED);
  assign presc_clr = (state == WL_IDLE) && bus.game_over;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .rst  (rst),
    .clk  (clk),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WL_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      WL_IDLE:  if (bus.game_over) next_state = WL_SHOW;
      WL_SHOW:  if (lock_done)     next_state = WL_ARMED;
      WL_ARMED: if (tap_edge)      next_state = WL_EXIT;
      WL_EXIT:                     next_state = WL_IDLE;
      default:                     next_state = WL_IDLE;
    endcase
  end

  always_comb begin
    active_d  = (state != WL_IDLE);
    armed_d   = (state == WL_ARMED);
    to_menu_d = (state == WL_EXIT);
  end

  // The tap history runs in every state so a press held across the lockout
  // never looks like a new edge once armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q    <= 1'b0;
      lock_cnt <= '0;
      cnt      <= '0;
      scene_q  <= S_LOSE;
    end else begin
      tap_q <= bus.tap;
      case (state)
        WL_IDLE: begin
          if (bus.game_over) begin
            scene_q  <= bus.game_won ? S_WIN : S_LOSE;
            lock_cnt <= '0;
          end
        end
        WL_SHOW: begin
          if (tick) begin
            cnt <= cnt + 4'd1;
            if (!lock_done) lock_cnt <= lock_cnt + 1'b1;
          end
        end
        WL_ARMED: begin
          if (tick && !tap_edge) cnt <= cnt + 4'd1;
        end
        WL_EXIT: cnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.active      = active_d;
  assign bus.armed       = armed_d;
  assign bus.to_menu     = to_menu_d;
  assign bus.scene_wl    = scene_q;
  assign bus.winLose_cnt = cnt;
  assign bus.state       = state;

endmodule

// File: doc/winlose_ctrl.md
WINLOSE_CTRL -- requirements
Module: winlose_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 6_250_000, clk cycles per blink tick (16 Hz at 100 MHz); legal range 2..2^23.
REQ-002 SHALL have parameter LOCK_TICKS, default 16, ticks of tap lockout after entering the result screen; legal range 1..255.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 game_over  input  1  one-cycle pulse from the play FSM: the round has ended.
REQ-006 game_won  input  1  result qualifier, sampled only in the game_over cycle; 1 = win.
REQ-007 tap  input  1  level from the mouse/touch block, same clock domain; 1 = pressed.
REQ-008 active  output  1  result screen is being shown.
REQ-009 scene_wl  output  3  latched result scene code: S_WIN (3'd5) or S_LOSE (3'd6).
REQ-010 winLose_cnt  output  4  blink counter; bit 3 drives the "tap to continue" blink in the result renderer.
REQ-011 armed  output  1  tap is currently accepted.
REQ-012 to_menu  output  1  one-cycle pulse: the scene FSM returns to S_MENU.

Function
REQ-013 SHALL implement FSM states IDLE, SHOW, ARMED and EXIT.
REQ-014 IDLE: active=0, armed=0, winLose_cnt=0; game_over=1 SHALL latch scene_wl=(game_won?S_WIN:S_LOSE), clear prescaler and lock counter, and go to SHOW next cycle.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 in SHOW/ARMED only; tick = (prescaler==TICK_DIV-1), prescaler wraps to 0 on that edge.
REQ-016 On each tick in SHOW/ARMED, winLose_cnt SHALL increment modulo 16 (15 wraps to 0).
REQ-017 First tick SHALL occur TICK_DIV cycles after the first SHOW cycle; winLose_cnt=1 from cycle TICK_DIV of SHOW.
REQ-018 SHOW: lock counter increments per tick; the tick that brings it to LOCK_TICKS SHALL move to ARMED next cycle; tap ignored.
REQ-019 ARMED: armed=1; rising edge of tap (tap=1 and tap registered previous cycle =0) SHALL move to EXIT next cycle.
REQ-020 Tap registered copy SHALL update every cycle in all states, so a tap held from SHOW into ARMED produces no edge until released and re-pressed.
REQ-021 Tap edge and tick in the same ARMED cycle: EXIT taken, winLose_cnt SHALL NOT increment.
REQ-022 EXIT: to_menu=1, active=1, armed=0 for exactly one cycle, then IDLE; winLose_cnt cleared on entering IDLE.
REQ-023 game_over in SHOW/ARMED/EXIT SHALL be ignored; scene_wl unchanged.
REQ-024 active=1 in SHOW, ARMED, EXIT; scene_wl SHALL hold its value through IDLE until the next game_over.
REQ-025 All outputs SHALL be registered or decoded from registered state only; no combinational path from any input to an output.

Reset
REQ-026 rst=1 on a clk edge SHALL force IDLE, prescaler=0, lock counter=0, tap register=0, winLose_cnt=0, active=0, armed=0, to_menu=0, scene_wl=S_LOSE, regardless of state, including mid-SHOW or in EXIT (no to_menu pulse emitted).
REQ-027 rst SHALL dominate a simultaneous game_over or tap.

Structure
REQ-028 Scene codes S_START..S_LOSE (3'd0..3'd6) SHALL come from the shared scene definitions header, not local literals.
REQ-029 Prescaler SHALL be a sub-module tick_gen (ports rst, clk, en, clr, tick, parameter DIV).
REQ-030 Prescaler width SHALL be $clog2(TICK_DIV); lock counter 8 bits.

Verification (TICK_DIV=4, LOCK_TICKS=16)
REQ-031 game_over=1, game_won=1 at cycle 0 -> cycle 1 active=1, scene_wl=5; winLose_cnt=1 at cycle 5, 2 at cycle 9; armed=1 at cycle 66 with winLose_cnt=0.
REQ-032 tap held high from cycle 10 through cycle 80 -> no to_menu; release at 81, press at 85 -> to_menu=1 at cycle 86 only, IDLE at 87 with winLose_cnt=0, scene_wl still 5.
REQ-033 tap pulse during SHOW (cycle 20) -> ignored, armed still rises at cycle 66.
REQ-034 game_over with game_won=0 while ARMED after a win -> scene_wl stays 5; a later game_over in IDLE with game_won=0 -> scene_wl=6.
REQ-035 rst at cycle 30 of SHOW -> next cycle all outputs at reset values; no to_menu.
REQ-036 tap edge coinciding with tick while ARMED and winLose_cnt=7 -> EXIT, winLose_cnt stays 7 during the to_menu cycle.
